// File: rtl/stim_signal_gen.sv
// stim_signal_gen
// Synthetic test-signal source for the moving-average / moving-median chain.
// Each enabled cycle emits one signed 16-bit sample: saturated sum of a DC
// level, an optional square wave and optional shaped LFSR noise. A periodic
// spike overrides the sum so the median path sees a known outlier pattern.
//
// Optional feature macro: SPIKE_BURST_EN (adds burst_len, multi-cycle spikes).
//
// Ports:
//   clk            system clock
//   reset          synchronous active-low reset
//   enable         run (1) / freeze (0)
//   mode           0=DC, 1=DC+square, 2=DC+noise, 3=DC+square+noise
//   level          signed DC offset
//   sq_amp         signed square amplitude
//   half_period    square half-period in cycles (0 behaves as 1)
//   noise_shift    arithmetic right shift applied to the noise word
//   spike_interval cycles between spikes (0 disables)
//   spike_value    signed value driven during a spike
//   burst_len      spike burst length, 0 behaves as 1 (SPIKE_BURST_EN only)
//   dataout        generated sample
//   valid          dataout is live
//   spike_flag     dataout is a spike this cycle
//   spike_count    spikes (bursts) emitted since reset, wrapping
//
// Spike FSM:
//   state   | meaning
//   S_IDLE  | spikes disabled (spike_interval=0), sp_cnt held at 0
//   S_COUNT | counting cycles towards the next spike
//   S_FIRE  | dataout carries spike_value, spike_flag high

module stim_signal_gen #(
  parameter logic [31:0] G_LFSR_SEED = 32'hACE12468,
  parameter int          G_CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic signed [15:0]     level,
  input  logic signed [15:0]     sq_amp,
  input  logic [G_CNT_WIDTH-1:0] half_period,
  input  logic [3:0]             noise_shift,
  input  logic [G_CNT_WIDTH-1:0] spike_interval,
  input  logic signed [15:0]     spike_value,
`ifdef SPIKE_BURST_EN
  input  logic [3:0]             burst_len,
`endif
  output logic signed [15:0]     dataout,
  output logic                   valid,
  output logic                   spike_flag,
  output logic [31:0]            spike_count
);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_FIRE} state_t;

  localparam logic [G_CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [G_CNT_WIDTH-1:0] CNT_ONE  = {{(G_CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [31:0]            LFSR_TAPS = 32'h8020_0003;

  state_t                   state, state_nxt;
  logic [G_CNT_WIDTH-1:0]   sp_cnt, sp_cnt_nxt;
  logic                     new_spike;
  logic                     burst_last;

  logic [31:0]              lfsr, lfsr_adv, lfsr_nxt;
  logic                     phase;
  logic [G_CNT_WIDTH-1:0]   hp_cnt, hp_max;
  logic                     hp_term;

  logic signed [15:0]       sq_term;
  logic signed [15:0]       noise;
  logic signed [17:0]       sum;
  logic signed [15:0]       sum_sat;
  logic signed [15:0]       sample_nxt;
  logic                     flag_nxt;

`ifdef SPIKE_BURST_EN
  logic [3:0] bst_cnt, bst_cnt_nxt;
  logic [3:0] burst_max;

  assign burst_max  = (burst_len == 4'd0) ? 4'd1 : burst_len;
  assign burst_last = (bst_cnt >= burst_max - 4'd1);
`else
  assign burst_last = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      sp_cnt <= CNT_ZERO;
`ifdef SPIKE_BURST_EN
      bst_cnt <= 4'd0;
`endif
    end else begin
      state  <= state_nxt;
      sp_cnt <= sp_cnt_nxt;
`ifdef SPIKE_BURST_EN
      bst_cnt <= bst_cnt_nxt;
`endif
    end
  end

  // Next-state logic. The cycle that leaves IDLE or finishes a spike already
  // occupies slot 0 of the next interval, so COUNT resumes at 1 and the
  // spike-to-spike period equals spike_interval exactly.
  always_comb begin
    state_nxt  = state;
    sp_cnt_nxt = sp_cnt;
    new_spike  = 1'b0;
`ifdef SPIKE_BURST_EN
    bst_cnt_nxt = bst_cnt;
`endif
    if (enable) begin
      case (state)
        S_IDLE: begin
          sp_cnt_nxt = CNT_ZERO;
          if (spike_interval != CNT_ZERO) begin
            state_nxt  = S_COUNT;
            sp_cnt_nxt = CNT_ONE;
          end
        end
        S_COUNT: begin
          if (spike_interval == CNT_ZERO) begin
            state_nxt  = S_IDLE;
            sp_cnt_nxt = CNT_ZERO;
          end else if (sp_cnt >= spike_interval - CNT_ONE) begin
            state_nxt  = S_FIRE;
            sp_cnt_nxt = CNT_ZERO;
            new_spike  = 1'b1;
`ifdef SPIKE_BURST_EN
            bst_cnt_nxt = 4'd0;
`endif
          end else begin
            sp_cnt_nxt = sp_cnt + CNT_ONE;
          end
        end
        S_FIRE: begin
          if (!burst_last) begin
`ifdef SPIKE_BURST_EN
            bst_cnt_nxt = bst_cnt + 4'd1;
`endif
          end else if (spike_interval == CNT_ZERO) begin
            state_nxt  = S_IDLE;
            sp_cnt_nxt = CNT_ZERO;
          end else if (spike_interval == CNT_ONE) begin
            state_nxt  = S_FIRE;
            sp_cnt_nxt = CNT_ZERO;
            new_spike  = 1'b1;
`ifdef SPIKE_BURST_EN
            bst_cnt_nxt = 4'd0;
`endif
          end else begin
            state_nxt  = S_COUNT;
            sp_cnt_nxt = CNT_ONE;
          end
        end
        default: begin
          state_nxt  = S_IDLE;
          sp_cnt_nxt = CNT_ZERO;
        end
      endcase
    end
  end

  // Output logic: next sample, decoded from the state being entered so the
  // registered spike_flag lines up with the FIRE state.
  always_comb begin
    hp_max  = (half_period == CNT_ZERO) ? CNT_ONE : half_period;
    hp_term = (hp_cnt >= hp_max - CNT_ONE);

    lfsr_adv = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    lfsr_nxt = (lfsr_adv == 32'd0) ? G_LFSR_SEED : lfsr_adv;

    // Negating -32768 does not fit in 16 bits; clamp it to +32767.
    if (phase)
      sq_term = sq_amp;
    else if (sq_amp == 16'sh8000)
      sq_term = 16'sh7FFF;
    else
      sq_term = -sq_amp;

    noise = $signed(lfsr[15:0]) >>> noise_shift;

    sum = {{2{level[15]}}, level};
    if (mode[0]) sum = sum + {{2{sq_term[15]}}, sq_term};
    if (mode[1]) sum = sum + {{2{noise[15]}}, noise};

    if (sum > 18'sd32767)
      sum_sat = 16'sh7FFF;
    else if (sum < -18'sd32768)
      sum_sat = 16'sh8000;
    else
      sum_sat = sum[15:0];

    flag_nxt   = enable && (state_nxt == S_FIRE);
    sample_nxt = 16'sd0;
    if (enable) sample_nxt = flag_nxt ? spike_value : sum_sat;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr        <= G_LFSR_SEED;
      phase       <= 1'b1;
      hp_cnt      <= CNT_ZERO;
      dataout     <= 16'sd0;
      valid       <= 1'b0;
      spike_flag  <= 1'b0;
      spike_count <= 32'd0;
    end else begin
      dataout    <= sample_nxt;
      valid      <= enable;
      spike_flag <= flag_nxt;
      if (enable) begin
        lfsr <= lfsr_nxt;
        if (hp_term) begin
          phase  <= ~phase;
          hp_cnt <= CNT_ZERO;
        end else begin
          hp_cnt <= hp_cnt + CNT_ONE;
        end
        if (new_spike) spike_count <= spike_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_stim_signal_gen.sv
module tb_stim_signal_gen;

  logic               clk;
  logic               reset;
  logic               enable;
  logic [1:0]         mode;
  logic signed [15:0] level;
  logic signed [15:0] sq_amp;
  logic [15:0]        half_period;
  logic [3:0]         noise_shift;
  logic [15:0]        spike_interval;
  logic signed [15:0] spike_value;
`ifdef SPIKE_BURST_EN
  logic [3:0]         burst_len;
`endif
  logic signed [15:0] dataout;
  logic               valid;
  logic               spike_flag;
  logic [31:0]        spike_count;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] SEED = 32'hACE12468;

  stim_signal_gen dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .mode           (mode),
    .level          (level),
    .sq_amp         (sq_amp),
    .half_period    (half_period),
    .noise_shift    (noise_shift),
    .spike_interval (spike_interval),
    .spike_value    (spike_value),
`ifdef SPIKE_BURST_EN
    .burst_len      (burst_len),
`endif
    .dataout        (dataout),
    .valid          (valid),
    .spike_flag     (spike_flag),
    .spike_count    (spike_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: x^32+x^22+x^2+x+1, right-shifting Galois form.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) begin
      n[31] = ~n[31];
      n[21] = ~n[21];
      n[1]  = ~n[1];
      n[0]  = ~n[0];
    end
    if (n == 32'd0) n = SEED;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic set_defaults();
    enable         = 1'b1;
    mode           = 2'd0;
    level          = 16'sd0;
    sq_amp         = 16'sd0;
    half_period    = 16'd1;
    noise_shift    = 4'd0;
    spike_interval = 16'd0;
    spike_value    = 16'sd0;
`ifdef SPIKE_BURST_EN
    burst_len      = 4'd1;
`endif
  endtask

  task automatic test_reset();
    set_defaults();
    level = 16'sd1234;
    reset = 1'b0;
    tick();
    tick();
    checks++; if (dataout !== 16'sd0) begin failures++; $display("FAIL reset_dataout got=%0d exp=0", dataout); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid); end
    checks++; if (spike_flag !== 1'b0) begin failures++; $display("FAIL reset_flag got=%0b exp=0", spike_flag); end
    checks++; if (spike_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", spike_count); end
    reset = 1'b1;
  endtask

  task automatic test_dc();
    set_defaults();
    do_reset();
    level = 16'sd1000;
    tick();
    checks++; if (dataout !== 16'sd1000) begin failures++; $display("FAIL dc_first got=%0d exp=1000", dataout); end
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL dc_valid got=%0b exp=1", valid); end
    checks++; if (spike_flag !== 1'b0) begin failures++; $display("FAIL dc_flag got=%0b exp=0", spike_flag); end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (dataout !== 16'sd1000) begin failures++; $display("FAIL dc_hold[%0d] got=%0d exp=1000", i, dataout); end
    end
  endtask

  task automatic run_square(input string name, input logic signed [15:0] lv,
                            input logic signed [15:0] amp, input logic [15:0] hp,
                            input int hp_eff, input logic signed [15:0] pos,
                            input logic signed [15:0] neg);
    logic signed [15:0] e;
    set_defaults();
    do_reset();
    mode = 2'd1; level = lv; sq_amp = amp; half_period = hp;
    for (int k = 0; k < 16; k++) begin
      tick();
      e = (((k / hp_eff) % 2) == 0) ? pos : neg;
      checks++; if (dataout !== e) begin failures++; $display("FAIL %s[%0d] got=%0d exp=%0d", name, k, dataout, e); end
    end
  endtask

  task automatic test_square();
    run_square("sq_hp4",   16'sd0,      16'sd500,   16'd4, 4, 16'sd500,    -16'sd500);
    run_square("sq_hp0",   16'sd0,      16'sd500,   16'd0, 1, 16'sd500,    -16'sd500);
    run_square("sq_satp",  16'sd32000,  16'sd2000,  16'd1, 1, 16'sd32767,  16'sd30000);
    run_square("sq_satn",  -16'sd32000, 16'sd2000,  16'd1, 1, -16'sd30000, -16'sd32768);
    run_square("sq_minamp", 16'sd0,     -16'sd32768, 16'd1, 1, -16'sd32768, 16'sd32767);
  endtask

  task automatic test_noise();
    logic [31:0]        m;
    logic signed [15:0] nz;
    logic signed [15:0] e;
    set_defaults();
    do_reset();
    m = SEED;
    mode = 2'd2; level = 16'sd100; noise_shift = 4'd15;
    for (int k = 0; k < 40; k++) begin
      tick();
      nz = m[15:0];
      nz = nz >>> 15;
      e = 16'sd100 + nz;
      m = lfsr_step(m);
      checks++; if (dataout !== e) begin failures++; $display("FAIL noise15[%0d] got=%0d exp=%0d", k, dataout, e); end
      checks++; if (dataout !== 16'sd99 && dataout !== 16'sd100) begin failures++; $display("FAIL noise15_range[%0d] got=%0d exp=99..100", k, dataout); end
    end
    level = 16'sd0; noise_shift = 4'd0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      e = m[15:0];
      m = lfsr_step(m);
      checks++; if (dataout !== e) begin failures++; $display("FAIL noise0[%0d] got=%0d exp=%0d", k, dataout, e); end
    end
  endtask

  task automatic test_spikes();
    logic ef;
    set_defaults();
    do_reset();
    spike_interval = 16'd10; spike_value = -16'sd20000;
    for (int k = 1; k <= 50; k++) begin
      tick();
      ef = ((k % 10) == 0);
      checks++; if (spike_flag !== ef) begin failures++; $display("FAIL spk10_flag[%0d] got=%0b exp=%0b", k, spike_flag, ef); end
      checks++; if (dataout !== (ef ? -16'sd20000 : 16'sd0)) begin failures++; $display("FAIL spk10_data[%0d] got=%0d", k, dataout); end
    end
    checks++; if (spike_count !== 32'd5) begin failures++; $display("FAIL spk10_count got=%0d exp=5", spike_count); end

    // interval 1: one COUNT cycle, then every cycle fires
    do_reset();
    spike_interval = 16'd1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      ef = (k >= 2);
      checks++; if (spike_flag !== ef) begin failures++; $display("FAIL spk1_flag[%0d] got=%0b exp=%0b", k, spike_flag, ef); end
    end
    checks++; if (spike_count !== 32'd5) begin failures++; $display("FAIL spk1_count got=%0d exp=5", spike_count); end

    // interval dropped to 0 while counting: no spike
    do_reset();
    spike_interval = 16'd10;
    for (int k = 0; k < 5; k++) tick();
    spike_interval = 16'd0;
    for (int k = 0; k < 15; k++) begin
      tick();
      checks++; if (spike_flag !== 1'b0) begin failures++; $display("FAIL spk_drop_flag[%0d] got=%0b exp=0", k, spike_flag); end
    end
    checks++; if (spike_count !== 32'd0) begin failures++; $display("FAIL spk_drop_count got=%0d exp=0", spike_count); end
  endtask

  task automatic test_freeze();
    logic               ef;
    logic signed [15:0] e;
    int                 k;
    set_defaults();
    do_reset();
    mode = 2'd1; sq_amp = 16'sd500; half_period = 16'd4;
    spike_interval = 16'd10; spike_value = -16'sd20000;
    k = 0;
    for (int n = 0; n < 32; n++) begin
      if (n >= 6 && n < 13) begin
        enable = 1'b0;
        tick();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL frz_valid[%0d] got=%0b exp=0", n, valid); end
        checks++; if (dataout !== 16'sd0) begin failures++; $display("FAIL frz_data[%0d] got=%0d exp=0", n, dataout); end
        checks++; if (spike_flag !== 1'b0) begin failures++; $display("FAIL frz_flag[%0d] got=%0b exp=0", n, spike_flag); end
      end else begin
        enable = 1'b1;
        tick();
        k++;
        ef = ((k % 10) == 0);
        e  = ef ? -16'sd20000 : ((((k - 1) / 4) % 2) == 0 ? 16'sd500 : -16'sd500);
        checks++; if (dataout !== e) begin failures++; $display("FAIL frz_resume[%0d] got=%0d exp=%0d", k, dataout, e); end
        checks++; if (spike_flag !== ef) begin failures++; $display("FAIL frz_rflag[%0d] got=%0b exp=%0b", k, spike_flag, ef); end
      end
    end
    checks++; if (spike_count !== 32'd2) begin failures++; $display("FAIL frz_count got=%0d exp=2", spike_count); end
  endtask

  task automatic test_reset_mid();
    set_defaults();
    do_reset();
    spike_interval = 16'd1; spike_value = 16'sd7000;
    for (int k = 0; k < 5; k++) tick();
    checks++; if (spike_flag !== 1'b1) begin failures++; $display("FAIL mid_pre_flag got=%0b exp=1", spike_flag); end
    reset = 1'b0;
    tick();
    checks++; if (spike_count !== 32'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", spike_count); end
    checks++; if (spike_flag !== 1'b0) begin failures++; $display("FAIL mid_flag got=%0b exp=0", spike_flag); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%0b exp=0", valid); end
    checks++; if (dataout !== 16'sd0) begin failures++; $display("FAIL mid_data got=%0d exp=0", dataout); end
    reset = 1'b1;
  endtask

  initial begin
    set_defaults();
    reset = 1'b0;
    test_reset();
    test_dc();
    test_square();
    test_noise();
    test_spikes();
    test_freeze();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
